// File: rtl/sata_oob_decoder.sv
// sata_oob_decoder: measures squelch burst/gap lengths and pulses cominit or comwake
// once AMOUNT valid bursts with consistently classified gaps have been seen.
module sata_oob_decoder #(
  parameter int BURSTMIN   = 8,
  parameter int BURSTMAX   = 24,
  parameter int WAKEGAPMIN = 12,
  parameter int WAKEGAPMAX = 20,
  parameter int INITGAPMIN = 36,
  parameter int INITGAPMAX = 60,
  parameter int AMOUNT     = 4
) (
  input  logic clk,
  input  logic reset,
  input  logic rxelecidle,
  output logic cominit,
  output logic comwake,
  output logic busy
);
  localparam int LW = $clog2(INITGAPMAX + 2);
  localparam int CW = $clog2(AMOUNT + 1);
  localparam logic [LW-1:0] len_one   = LW'(1);
  localparam logic [LW-1:0] len_sat   = LW'(INITGAPMAX + 1);
  localparam logic [LW-1:0] len_bover = LW'(BURSTMAX + 1);
  localparam logic [LW-1:0] bmin = LW'(BURSTMIN);
  localparam logic [LW-1:0] bmax = LW'(BURSTMAX);
  localparam logic [LW-1:0] wmin = LW'(WAKEGAPMIN);
  localparam logic [LW-1:0] wmax = LW'(WAKEGAPMAX);
  localparam logic [LW-1:0] imin = LW'(INITGAPMIN);
  localparam logic [LW-1:0] imax = LW'(INITGAPMAX);
  localparam logic [CW-1:0] cnt_one  = CW'(1);
  localparam logic [CW-1:0] cnt_done = CW'(AMOUNT);

  typedef enum logic [1:0] {st_flush, st_idle, st_burst, st_gap} state_t;

  logic [1:0] sync;
  logic active;
  state_t state, state_n;
  logic [LW-1:0] len, len_n, len_inc;
  logic [CW-1:0] cnt, cnt_n, cnt_inc;
  logic cls, cls_n;
  logic burst_ok, gap_wake, gap_init, gap_ok, done;
  logic cominit_n, comwake_n, busy_n;

  assign active = ~sync[1];

  always_comb begin
    len_inc  = (len == len_sat) ? len : len + len_one;
    cnt_inc  = cnt + cnt_one;
    burst_ok = (len >= bmin) && (len <= bmax);
    gap_wake = (len >= wmin) && (len <= wmax);
    gap_init = (len >= imin) && (len <= imax);
    gap_ok   = gap_wake || gap_init;
    done     = (state == st_burst) && !active && burst_ok && (cnt_inc == cnt_done);
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      sync    <= 2'b11;
      state   <= st_flush;
      len     <= '0;
      cnt     <= '0;
      cls     <= 1'b1;
      cominit <= 1'b0;
      comwake <= 1'b0;
      busy    <= 1'b0;
    end else begin
      sync    <= {sync[0], rxelecidle};
      state   <= state_n;
      len     <= len_n;
      cnt     <= cnt_n;
      cls     <= cls_n;
      cominit <= cominit_n;
      comwake <= comwake_n;
      busy    <= busy_n;
    end
  end

  // cls: 1 = init/reset gap class, 0 = wake gap class
  always_comb begin
    state_n = state;
    len_n   = len;
    cnt_n   = cnt;
    cls_n   = cls;
    case (state)
      st_flush: state_n = active ? st_flush : st_idle;
      st_idle: if (active) begin
        state_n = st_burst;
        len_n   = len_one;
        cnt_n   = '0;
      end
      st_burst: if (active) begin
        len_n = len_inc;
        if (len_inc == len_bover) begin
          state_n = st_flush;
          cnt_n   = '0;
        end
      end else if (!burst_ok || done) begin
        state_n = st_idle;
        cnt_n   = '0;
      end else begin
        state_n = st_gap;
        len_n   = len_one;
        cnt_n   = cnt_inc;
      end
      st_gap: if (!active) begin
        len_n = len_inc;
        if (len_inc == len_sat) begin
          state_n = st_idle;
          cnt_n   = '0;
        end
      end else begin
        state_n = st_burst;
        len_n   = len_one;
        if (gap_ok && cnt == cnt_one) cls_n = gap_init;
        else if (!gap_ok || gap_init != cls) cnt_n = '0;
      end
      default: state_n = st_flush;
    endcase
  end

  always_comb begin
    cominit_n = done && cls;
    comwake_n = done && !cls;
    busy_n    = (state_n == st_burst) || (state_n == st_gap);
  end
endmodule

// File: tb/tb_sata_oob_decoder.sv
// tb_sata_oob_decoder: drives burst/gap sequences, predicts pulses from a sequence-level
// model into a queue, and a monitor checks every pulse against that queue.
module tb_sata_oob_decoder;
  localparam int BURSTMIN = 8, BURSTMAX = 24, WAKEGAPMIN = 12, WAKEGAPMAX = 20;
  localparam int INITGAPMIN = 36, INITGAPMAX = 60, AMOUNT = 4;

  logic clk = 1'b0, reset = 1'b1, rxelecidle = 1'b1;
  logic cominit, comwake, busy;

  sata_oob_decoder #(.BURSTMIN(BURSTMIN), .BURSTMAX(BURSTMAX), .WAKEGAPMIN(WAKEGAPMIN),
    .WAKEGAPMAX(WAKEGAPMAX), .INITGAPMIN(INITGAPMIN), .INITGAPMAX(INITGAPMAX), .AMOUNT(AMOUNT))
    dut (.clk(clk), .reset(reset), .rxelecidle(rxelecidle), .cominit(cominit), .comwake(comwake), .busy(busy));

  always #5 clk = ~clk;

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  typedef struct {bit init; int at;} exp_t;
  exp_t q[$];
  exp_t x;
  int checks = 0, errors = 0;

  int m_cnt = 0, pend = 0, last_e = 0;
  bit m_cls = 1'b1, m_seq = 1'b0;

  task automatic chk(string name, int act, int req);
    checks++;
    if (act != req) begin
      errors++;
      $display("FAIL %s: got %0d expected %0d (cycle %0d)", name, act, req, cyc);
    end
  endtask

  // 0 = invalid, 1 = wake, 2 = init
  function automatic int gclass(int g);
    if (g >= WAKEGAPMIN && g <= WAKEGAPMAX) return 1;
    if (g >= INITGAPMIN && g <= INITGAPMAX) return 2;
    return 0;
  endfunction

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic do_gap(int g);
    rxelecidle = 1'b1;
    repeat (g) tick();
    pend += g;
  endtask

  task automatic do_burst(int l);
    int c;
    if (m_seq) begin
      c = gclass(pend);
      if (pend > INITGAPMAX) m_cnt = 0;
      else if (c != 0 && m_cnt == 1) m_cls = (c == 2);
      else if (c == 0 || (c == 2) != m_cls) m_cnt = 0;
    end
    pend = 0;
    rxelecidle = 1'b0;
    repeat (l) tick();
    rxelecidle = 1'b1;
    last_e = cyc + 1;
    if (l < BURSTMIN || l > BURSTMAX) begin
      m_cnt = 0;
      m_seq = 1'b0;
    end else begin
      m_cnt++;
      if (m_cnt == AMOUNT) begin
        q.push_back('{m_cls, last_e + 2});
        m_cnt = 0;
        m_seq = 1'b0;
      end else m_seq = 1'b1;
    end
  endtask

  task automatic do_reset();
    reset = 1'b1;
    repeat (3) tick();
    chk("reset_cominit", cominit, 0);
    chk("reset_comwake", comwake, 0);
    chk("reset_busy", busy, 0);
    m_cnt = 0;
    m_seq = 1'b0;
    m_cls = 1'b1;
    pend = 0;
    reset = 1'b0;
    repeat (3) tick();
    chk("post_reset_busy", busy, 0);
  endtask

  always @(negedge clk) begin
    if (!reset && (cominit || comwake)) begin
      chk("exclusive", int'(cominit && comwake), 0);
      if (q.size() == 0) begin
        checks++;
        errors++;
        $display("FAIL unexpected_pulse: cominit=%0d comwake=%0d at cycle %0d, none expected", cominit, comwake, cyc);
      end else begin
        x = q.pop_front();
        chk("pulse_type_cominit", int'(cominit), int'(x.init));
        chk("pulse_cycle", cyc, x.at);
      end
    end
  end

  initial begin
    #1_000_000;
    $display("FAIL timeout: simulation did not complete");
    $fatal(1, "timeout");
  end

  initial begin
    int bl, gl, r;
    int bnd[4] = '{11, 21, 35, 61};
    #1;
    do_reset();
    // four 16-cycle bursts, 48-cycle gaps -> cominit
    for (int i = 0; i < 4; i++) begin
      do_burst(16);
      do_gap(10);
      if (i == 0) chk("busy_in_gap", busy, 1);
      do_gap(38);
    end
    do_gap(80);
    // six bursts with 16-cycle gaps -> one comwake, then busy drops on gap timeout
    for (int i = 0; i < 6; i++) begin
      do_burst(16);
      if (i < 5) do_gap(16);
    end
    do_gap(INITGAPMAX + 2);
    chk("busy_before_timeout", busy, 1);
    do_gap(1);
    chk("busy_after_timeout", busy, 0);
    do_gap(20);
    // invalid 30-cycle gap restarts the sequence
    do_burst(16);
    do_gap(48);
    do_burst(16);
    do_gap(30);
    for (int i = 0; i < 4; i++) begin
      do_burst(16);
      do_gap(48);
    end
    do_gap(80);
    // class mismatch then overlong burst
    do_burst(16); do_gap(48);
    do_burst(16); do_gap(16);
    do_burst(16); do_gap(48);
    do_burst(25); do_gap(80);
    // boundary lengths
    do_burst(7);  do_gap(12);
    do_burst(24); do_gap(12);
    do_burst(24); do_gap(20);
    do_burst(24); do_gap(20);
    do_burst(24); do_gap(80);
    // reset after three valid bursts discards progress
    do_burst(16); do_gap(48);
    do_burst(16); do_gap(48);
    do_burst(16); do_gap(20);
    do_reset();
    do_gap(5);
    do_burst(16);
    do_gap(80);
    chk("after_reset_cominit", cominit, 0);
    chk("after_reset_comwake", comwake, 0);
    // randomized traffic
    repeat (250) begin
      r = $urandom_range(0, 9);
      bl = (r < 7) ? $urandom_range(BURSTMIN, BURSTMAX) : (r == 7) ? $urandom_range(1, BURSTMIN - 1) :
           (r == 8) ? $urandom_range(BURSTMAX + 1, BURSTMAX + 6) : (($urandom_range(0, 1) == 1) ? BURSTMAX : BURSTMIN);
      do_burst(bl);
      r = $urandom_range(0, 9);
      gl = (r < 4) ? $urandom_range(WAKEGAPMIN, WAKEGAPMAX) : (r < 8) ? $urandom_range(INITGAPMIN, INITGAPMAX) :
           (r == 8) ? bnd[$urandom_range(0, 3)] : $urandom_range(1, 70);
      do_gap(gl);
    end
    do_gap(80);
    chk("pending_expected_pulses", q.size(), 0);
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule
